// File: rtl/cursor_pkg.sv
// Shared types and constants for the paint cursor path: direction codes,
// the move FSM states, datapath widths and the button priority encoder.
package cursor_pkg;

    localparam int POS_W   = 11;
    localparam int TIMER_W = 25;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_e;

    // pressed = {up, down, left, right}; up wins, right loses.
    function automatic logic [1:0] pick_dir(input logic [3:0] pressed);
        if (pressed[3])      return DIR_UP;
        else if (pressed[2]) return DIR_DOWN;
        else if (pressed[1]) return DIR_LEFT;
        else                 return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw active-low button: two-flop synchroniser followed by a counter that
// accepts a level change only after DEBOUNCE consecutive differing cycles.
module button_debounce #(
    parameter int DEBOUNCE = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic but_n_i,
    output logic pressed_o
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every assignment below is non-blocking so all flops sample their
    // inputs from the same edge; blocking here would collapse the synchroniser.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ~but_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first, so every path assigns every output and no latch forms.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign pressed_o = level_q;

endmodule

// File: rtl/cursor_mover.sv
// Button-driven cursor position with press, hold-delay and auto-repeat moves.
// Define CURSOR_WRAP_EN to wrap at the screen limits instead of clamping.
module cursor_mover
    import cursor_pkg::*;
#(
    parameter int SIZE          = 8,
    parameter int STEP          = 4,
    parameter int W_RES         = 640,
    parameter int H_RES         = 480,
    parameter int DEBOUNCE      = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 2000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              up_but,
    input  logic              down_but,
    input  logic              left_but,
    input  logic              right_but,
    output logic [POS_W-1:0]  x_cursor,
    output logic [POS_W-1:0]  y_cursor,
    output logic              moved,
    output logic [1:0]        dir
);

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [POS_W-1:0]   X_MAX   = POS_W'(W_RES - SIZE - 2);
    localparam logic [POS_W-1:0]   Y_MAX   = POS_W'(H_RES - SIZE - 2);
    localparam logic [POS_W-1:0]   X0      = POS_W'(W_RES / 2 - SIZE / 2);
    localparam logic [POS_W-1:0]   Y0      = POS_W'(H_RES / 2 - SIZE / 2);
    localparam logic [POS_W-1:0]   STEP_P  = POS_W'(STEP);
    localparam logic [TIMER_W-1:0] T_DELAY = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] T_PER   = TIMER_W'(REPEAT_PERIOD - 1);

    logic [3:0] pressed;
    logic       any_pressed;
    logic [1:0] active_dir;

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_up (
        .clock(clock), .reset(reset), .but_n_i(up_but),    .pressed_o(pressed[3])
    );
    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_down (
        .clock(clock), .reset(reset), .but_n_i(down_but),  .pressed_o(pressed[2])
    );
    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_left (
        .clock(clock), .reset(reset), .but_n_i(left_but),  .pressed_o(pressed[1])
    );
    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_right (
        .clock(clock), .reset(reset), .but_n_i(right_but), .pressed_o(pressed[0])
    );

    assign any_pressed = |pressed;
    assign active_dir  = pick_dir(pressed);

    // Towards zero: a step that would underflow lands on 0 (or wraps to lim).
    function automatic logic [POS_W-1:0] step_back(input logic [POS_W-1:0] pos,
                                                   input logic [POS_W-1:0] lim);
        if (pos < STEP_P) return WRAP_EN ? lim : '0;
        else              return pos - STEP_P;
    endfunction

    // Away from zero: sum kept one bit wider so it cannot overflow the compare.
    function automatic logic [POS_W-1:0] step_fwd(input logic [POS_W-1:0] pos,
                                                  input logic [POS_W-1:0] lim);
        logic [POS_W:0] sum;
        sum = {1'b0, pos} + {1'b0, STEP_P};
        if (sum > {1'b0, lim}) return WRAP_EN ? '0 : lim;
        else                   return sum[POS_W-1:0];
    endfunction

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [POS_W-1:0]   x_q, x_d;
    logic [POS_W-1:0]   y_q, y_d;
    logic [1:0]         dir_q, dir_d;
    logic               moved_q, moved_d;
    logic               do_move;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            x_q     <= X0;
            y_q     <= Y0;
            dir_q   <= DIR_UP;
            moved_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            moved_q <= moved_d;
        end
    end

    // Release takes precedence over a timer expiring on the same cycle.
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q != '0) ? timer_q - TIMER_W'(1) : timer_q;
        do_move = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_pressed) begin
                    do_move = 1'b1;
                    timer_d = T_DELAY;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!any_pressed) begin
                    state_d = IDLE;
                end else if (active_dir != dir_q) begin
                    do_move = 1'b1;
                    timer_d = T_DELAY;
                end else if (timer_q == '0) begin
                    do_move = 1'b1;
                    timer_d = T_PER;
                    state_d = REPEAT;
                end
            end
            REPEAT: begin
                if (!any_pressed) begin
                    state_d = IDLE;
                end else if (active_dir != dir_q) begin
                    do_move = 1'b1;
                    timer_d = T_DELAY;
                    state_d = HOLD;
                end else if (timer_q == '0) begin
                    do_move = 1'b1;
                    timer_d = T_PER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        moved_d = do_move;
        if (do_move) begin
            dir_d = active_dir;
            unique case (active_dir)
                DIR_UP:    y_d = step_back(y_q, Y_MAX);
                DIR_DOWN:  y_d = step_fwd(y_q, Y_MAX);
                DIR_LEFT:  x_d = step_back(x_q, X_MAX);
                DIR_RIGHT: x_d = step_fwd(x_q, X_MAX);
                default:   x_d = x_q;
            endcase
        end
    end

    assign x_cursor = x_q;
    assign y_cursor = y_q;
    assign moved    = moved_q;
    assign dir      = dir_q;

endmodule

// File: tb/tb_cursor_mover.sv
// Self-checking bench for cursor_mover: a cycle-stamped scoreboard of expected
// moves, a table of single-press vectors, and hand sequences for timing corners.
module tb_cursor_mover;

    localparam int DEB   = 4;
    localparam int RD    = 20;
    localparam int RP    = 8;
    localparam int LAT   = DEB + 3;
    localparam int STEP  = 4;
    localparam int X_MAX = 630;
    localparam int Y_MAX = 470;
    localparam int X0    = 316;
    localparam int Y0    = 236;
`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  btn_n = 4'hF;   // {up, down, left, right}, active-low
    logic [10:0] x_cursor;
    logic [10:0] y_cursor;
    logic        moved;
    logic [1:0]  dir;

    cursor_mover #(
        .DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock), .reset(reset),
        .up_but(btn_n[3]), .down_but(btn_n[2]),
        .left_but(btn_n[1]), .right_but(btn_n[0]),
        .x_cursor(x_cursor), .y_cursor(y_cursor),
        .moved(moved), .dir(dir)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int cyc; int x; int y; int d; } exp_t;
    typedef struct { logic [3:0] mask; int x; int y; int d; } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   mx;
    int   my;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int at, input int x, input int y, input int d);
        exp_t e;
        e.cyc = at; e.x = x; e.y = y; e.d = d;
        mx = x; my = y;
        sb.push_back(e);
    endtask

    // Reference move rules applied to the bench's own position model.
    task automatic push_move(input int at, input int d);
        int nx, ny;
        nx = mx; ny = my;
        case (d)
            0: ny = (my < STEP) ? (WRAP ? Y_MAX : 0) : my - STEP;
            1: ny = (my + STEP > Y_MAX) ? (WRAP ? 0 : Y_MAX) : my + STEP;
            2: nx = (mx < STEP) ? (WRAP ? X_MAX : 0) : mx - STEP;
            default: nx = (mx + STEP > X_MAX) ? (WRAP ? 0 : X_MAX) : mx + STEP;
        endcase
        push_exp(at, nx, ny, d);
    endtask

    // A press driven now is sampled at the next edge and moves LAT edges later.
    task automatic tap(input logic [3:0] mask, input int d);
        btn_n = ~mask;
        push_move(cyc + 1 + LAT, d);
        tick(12);
        btn_n = 4'hF;
        tick(16);
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("move_late", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (moved === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_move", cyc, -1);
            end else begin
                mon_e = sb.pop_front();
                check("move_cycle", cyc, mon_e.cyc);
                check("move_x", int'(x_cursor), mon_e.x);
                check("move_y", int'(y_cursor), mon_e.y);
                check("move_dir", int'(dir), mon_e.d);
            end
        end
    end

    vec_t tbl[7];
    int   c;
    int   at;
    int   nmov;

    initial begin
        tbl[0] = '{4'b0100, 340, 236, 1};
        tbl[1] = '{4'b0010, 336, 236, 2};
        tbl[2] = '{4'b0001, 340, 236, 3};
        tbl[3] = '{4'b1000, 340, 232, 0};
        tbl[4] = '{4'b1010, 340, 228, 0};
        tbl[5] = '{4'b0101, 340, 232, 1};
        tbl[6] = '{4'b0011, 336, 232, 2};

        reset = 1'b0;
        tick(3);
        check("rst_x", int'(x_cursor), X0);
        check("rst_y", int'(y_cursor), Y0);
        check("rst_moved", int'(moved), 0);
        check("rst_dir", int'(dir), 0);
        mx = X0; my = Y0;
        reset = 1'b1;
        tick(2);

        // Two-cycle glitch must not move anything.
        btn_n[3] = 1'b0;
        tick(2);
        btn_n[3] = 1'b1;
        tick(15);

        tap(4'b1000, 0);
        check("up_y", int'(y_cursor), 232);
        check("up_dir", int'(dir), 0);

        // Held right: first move, then delay, then periodic repeats.
        c = cyc;
        btn_n[0] = 1'b0;
        push_move(c + 1 + LAT, 3);
        for (int i = 0; i < 5; i++) push_move(c + 1 + LAT + RD + i * RP, 3);
        tick(58);
        btn_n = 4'hF;
        tick(20);
        check("hold_x", int'(x_cursor), 340);

        for (int i = 0; i < 7; i++) begin
            btn_n = ~tbl[i].mask;
            push_exp(cyc + 1 + LAT, tbl[i].x, tbl[i].y, tbl[i].d);
            tick(12);
            btn_n = 4'hF;
            tick(16);
        end

        // Up+left together, then drop up: left moves as soon as that is seen.
        c = cyc;
        btn_n = 4'b0101;
        push_move(c + 1 + LAT, 0);
        tick(12);
        btn_n[3] = 1'b1;
        push_move(cyc + 1 + LAT, 2);
        tick(12);
        btn_n = 4'hF;
        tick(20);
        check("prio_dir", int'(dir), 2);
        check("prio_x", int'(x_cursor), 332);
        check("prio_y", int'(y_cursor), 228);

        // Auto-repeat right up to x=628, releasing just before the next repeat.
        c = cyc;
        btn_n[0] = 1'b0;
        at = c + 1 + LAT;
        nmov = 0;
        while (mx < X_MAX - 2) begin
            push_move(at, 3);
            at += (nmov == 0) ? RD : RP;
            nmov++;
        end
        tick(at - 8 - cyc);
        btn_n = 4'hF;
        tick(20);
        check("edge_start_x", int'(x_cursor), 628);
        tap(4'b0001, 3);
        check("edge_x1", int'(x_cursor), mx);
        tap(4'b0001, 3);
        check("edge_x2", int'(x_cursor), mx);

        // Reset in REPEAT with right still held; must re-debounce afterwards.
        c = cyc;
        btn_n[0] = 1'b0;
        push_move(c + 1 + LAT, 3);
        push_move(c + 1 + LAT + RD, 3);
        tick(1 + LAT + RD + 4);
        reset = 1'b0;
        tick(3);
        check("rst2_x", int'(x_cursor), X0);
        check("rst2_y", int'(y_cursor), Y0);
        check("rst2_moved", int'(moved), 0);
        check("rst2_dir", int'(dir), 0);
        mx = X0; my = Y0;
        reset = 1'b1;
        push_move(cyc + 1 + LAT, 3);
        tick(12);
        btn_n = 4'hF;
        tick(20);
        check("rst2_move_x", int'(x_cursor), 320);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
